// File: rtl/hl2_atu_pkg.sv
// Shared ATU constants: default clock rate, ms-tick defaults and counter
// widths, used by this filter and by the ATU sequencer.
package hl2_atu_pkg;

  localparam int unsigned CLK_HZ_DEF      = 76_800_000;
  localparam int unsigned DEBOUNCE_MS_DEF = 5;
  localparam int unsigned STUCK_MS_DEF    = 12_000;

  // Debounce counter holds up to 255 ticks, stuck counter up to 65535.
  localparam int unsigned DEB_CNT_W   = 8;
  localparam int unsigned STUCK_CNT_W = 16;

  function automatic int unsigned ticks_per_ms(input int unsigned clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/atu_status_filter_if.sv
// AH-4 status bundle: raw KEY input, fault clear, and the filtered status outputs.
interface atu_status_filter_if;

  logic atu_key_n;
  logic clear_fault;
  logic atu_status;
  logic status_rise;
  logic status_fall;
  logic stuck_fault;

  modport master (
    output atu_key_n, clear_fault,
    input  atu_status, status_rise, status_fall, stuck_fault
  );

  modport slave (
    input  atu_key_n, clear_fault,
    output atu_status, status_rise, status_fall, stuck_fault
  );

endinterface

// File: rtl/atu_status_filter_ms_tick_gen.sv
// Free-running 1 ms prescaler: one-clock tick every CLK_HZ/1000 clocks,
// first tick CLK_HZ/1000 clocks after reset release.
module ms_tick_gen
  import hl2_atu_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned PERIOD = ticks_per_ms(CLK_HZ);
  localparam int unsigned CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..PERIOD-1 and register the tick on the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/atu_status_filter.sv
// AH-4 KEY debounce filter with edge pulses and stuck-tuning detection.
// Optional feature macro: ATU_STUCK_DETECT_EN (stuck counter, stuck_fault,
// clear_fault). When undefined, stuck_fault is tied low and clear_fault ignored.
module atu_status_filter
  import hl2_atu_pkg::*;
#(
  parameter int unsigned CLK_HZ      = CLK_HZ_DEF,
  parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEF,
  parameter int unsigned STUCK_MS    = STUCK_MS_DEF
) (
  input  logic clk,
  input  logic rst,
  atu_status_filter_if.slave bus
);

  localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEBOUNCE_MS - 1);

  logic                 tick;
  logic                 sync1, sync2;
  logic                 key_s;
  logic [DEB_CNT_W-1:0] deb_cnt;
  logic                 status, rise, fall;
  logic                 fault;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchronizer; the inversion makes 1 mean busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= ~bus.atu_key_n;
      sync2 <= sync1;
    end
  end

  assign key_s = sync2;

  // Debounce: count ticks while the input disagrees, toggle after DEBOUNCE_MS.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt <= '0;
      status  <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (key_s == status) begin
        deb_cnt <= '0;
      end else if (tick) begin
        if (deb_cnt == DEB_LAST) begin
          status  <= ~status;
          deb_cnt <= '0;
          rise    <= ~status;
          fall    <= status;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
    end
  end

`ifdef ATU_STUCK_DETECT_EN
  localparam logic [STUCK_CNT_W-1:0] STUCK_LAST = STUCK_CNT_W'(STUCK_MS - 1);
  localparam logic [STUCK_CNT_W-1:0] STUCK_MAX  = STUCK_CNT_W'(STUCK_MS);

  logic [STUCK_CNT_W-1:0] stuck_cnt;
  logic                   stuck_set;

  // The set fires only on the tick that reaches STUCK_MS, so a saturated
  // counter cannot re-assert the fault after it has been cleared.
  always_comb begin
    stuck_set = status && tick && (stuck_cnt == STUCK_LAST);
  end

  // Busy-time counter (saturating) and sticky fault; set beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      stuck_cnt <= '0;
      fault     <= 1'b0;
    end else begin
      if (!status || bus.clear_fault) begin
        stuck_cnt <= '0;
      end else if (tick && (stuck_cnt != STUCK_MAX)) begin
        stuck_cnt <= stuck_cnt + 1'b1;
      end
      if (stuck_set) begin
        fault <= 1'b1;
      end else if (bus.clear_fault) begin
        fault <= 1'b0;
      end
    end
  end
`else
  logic unused_clear_fault;
  assign unused_clear_fault = bus.clear_fault;
  assign fault = 1'b0;
`endif

  assign bus.atu_status  = status;
  assign bus.status_rise = rise;
  assign bus.status_fall = fall;
  assign bus.stuck_fault = fault;

endmodule

// File: tb/tb_atu_status_filter.sv
// Self-checking bench for atu_status_filter at CLK_HZ=10000 (10 clocks/ms),
// DEBOUNCE_MS=5, STUCK_MS=20. Honors ATU_STUCK_DETECT_EN like the design.
module tb_atu_status_filter;

  localparam int N   = 10;
  localparam int DEB = 5;
  localparam int STK = 20;
`ifdef ATU_STUCK_DETECT_EN
  localparam bit STUCK_EN = 1'b1;
`else
  localparam bit STUCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  atu_status_filter_if bus_if();

  atu_status_filter #(
    .CLK_HZ      (10000),
    .DEBOUNCE_MS (DEB),
    .STUCK_MS    (STK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Time is counted in clocks since reset release; a tick is visible
  // whenever that count is a positive multiple of N.
  bit m_valid = 1'b0;
  int m_cyc;
  bit m_sync[2];
  bit m_tick;
  int m_deb;
  bit m_st, m_rise, m_fall;
  int m_stk;
  bit m_fault;
  bit ks, tk, st, setc;

  always @(posedge clk) begin
    m_valid = 1'b1;
    if (rst) begin
      m_cyc = 0; m_sync[0] = 0; m_sync[1] = 0; m_tick = 0;
      m_deb = 0; m_st = 0; m_rise = 0; m_fall = 0; m_stk = 0; m_fault = 0;
    end else begin
      ks = m_sync[1]; tk = m_tick; st = m_st;
      m_rise = 0; m_fall = 0;
      if (ks == st) m_deb = 0;
      else if (tk) begin
        m_deb = m_deb + 1;
        if (m_deb == DEB) begin
          m_st = !st; m_deb = 0;
          m_rise = !st; m_fall = st;
        end
      end
      setc = st && tk && (m_stk == STK - 1);
      if (!st || bus_if.clear_fault) m_stk = 0;
      else if (tk && m_stk < STK) m_stk = m_stk + 1;
      if (STUCK_EN) begin
        if (setc) m_fault = 1;
        else if (bus_if.clear_fault) m_fault = 0;
      end
      m_sync[1] = m_sync[0];
      m_sync[0] = !bus_if.atu_key_n;
      m_cyc = m_cyc + 1;
      m_tick = (m_cyc % N) == 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("atu_status",  32'(bus_if.atu_status),  32'(m_st));
      check("status_rise", 32'(bus_if.status_rise), 32'(m_rise));
      check("status_fall", 32'(bus_if.status_fall), 32'(m_fall));
      check("stuck_fault", 32'(bus_if.stuck_fault), 32'(m_fault));
    end
  end

  task automatic cycles(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  int n, rises, falls, len;
  bit seen;

  initial begin
    bus_if.atu_key_n   = 1'b1;
    bus_if.clear_fault = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("reset_status", 32'(bus_if.atu_status),  0);
    check("reset_rise",   32'(bus_if.status_rise), 0);
    check("reset_fall",   32'(bus_if.status_fall), 0);
    check("reset_fault",  32'(bus_if.stuck_fault), 0);
    cycles(2);
    rst = 1'b0;
    cycles(30);

    // Clean step to busy: acceptance within 42..52 clocks, single rise.
    bus_if.atu_key_n = 1'b0;
    n = 0; rises = 0; falls = 0;
    while (!bus_if.atu_status && n < 100) begin
      @(negedge clk); n++;
      rises += int'(bus_if.status_rise); falls += int'(bus_if.status_fall);
    end
    check("rise_latency_in_window", 32'(n >= 42 && n <= 52), 1);
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      rises += int'(bus_if.status_rise); falls += int'(bus_if.status_fall);
    end
    check("fault_not_early", 32'(bus_if.stuck_fault), 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      rises += int'(bus_if.status_rise); falls += int'(bus_if.status_fall);
    end
    check("single_rise", 32'(rises), 1);
    check("no_fall_while_busy", 32'(falls), 0);
    check("fault_after_busy", 32'(bus_if.stuck_fault), 32'(STUCK_EN));
    bus_if.atu_key_n = 1'b1;
    cycles(100);
    check("released_status", 32'(bus_if.atu_status), 0);
    check("fault_sticky", 32'(bus_if.stuck_fault), 32'(STUCK_EN));
    bus_if.clear_fault = 1'b1;
    @(negedge clk);
    bus_if.clear_fault = 1'b0;
    check("fault_cleared", 32'(bus_if.stuck_fault), 0);

    // Short glitches never get accepted.
    seen = 0;
    for (int r = 0; r < 10; r++) begin
      bus_if.atu_key_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        seen |= bus_if.atu_status | bus_if.status_rise | bus_if.status_fall;
      end
      bus_if.atu_key_n = 1'b1;
      for (int i = 0; i < 22; i++) begin
        @(negedge clk);
        seen |= bus_if.atu_status | bus_if.status_rise | bus_if.status_fall;
      end
    end
    check("glitch_rejected", 32'(seen), 0);

    // Clear coinciding with the setting tick: the set wins.
    bus_if.atu_key_n = 1'b0;
    n = 0;
    while (!(m_st && m_tick && m_stk == STK - 1) && n < 500) begin
      @(negedge clk); n++;
    end
    check("set_tick_reached", 32'(n < 500), 1);
    bus_if.clear_fault = 1'b1;
    @(negedge clk);
    bus_if.clear_fault = 1'b0;
    check("set_beats_clear", 32'(bus_if.stuck_fault), 32'(STUCK_EN));
    // A later clear needs a fresh full busy interval before re-setting.
    bus_if.clear_fault = 1'b1;
    @(negedge clk);
    bus_if.clear_fault = 1'b0;
    cycles(150);
    check("no_reset_before_full_interval", 32'(bus_if.stuck_fault), 0);
    cycles(80);
    check("reset_after_full_interval", 32'(bus_if.stuck_fault), 32'(STUCK_EN));
    bus_if.atu_key_n = 1'b1;
    cycles(100);

    // Reset mid-debounce abandons the count; a full 5 ms is needed afterwards.
    bus_if.atu_key_n = 1'b0;
    n = 0;
    while (m_deb != 3 && n < 200) begin
      @(negedge clk); n++;
    end
    check("deb_three_reached", 32'(n < 200), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_status", 32'(bus_if.atu_status),  0);
    check("rst_rise",   32'(bus_if.status_rise), 0);
    check("rst_fault",  32'(bus_if.stuck_fault), 0);
    n = 0; rises = 0;
    while (!bus_if.atu_status && n < 100) begin
      @(negedge clk); n++;
      rises += int'(bus_if.status_rise);
    end
    check("post_reset_latency", 32'(n), 51);
    check("post_reset_one_rise", 32'(rises), 1);
    bus_if.atu_key_n = 1'b1;
    cycles(80);

    // Randomized runs including long busy stretches, clears and resets.
    for (int r = 0; r < 120; r++) begin
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(150, 400))
                                         : int'($urandom_range(1, 80));
      bus_if.atu_key_n = 1'($urandom_range(0, 1));
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        bus_if.clear_fault = ($urandom_range(0, 40) == 0);
        rst = ($urandom_range(0, 1500) == 0);
      end
    end
    bus_if.clear_fault = 1'b0;
    rst = 1'b0;
    cycles(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
